// File: rtl/axi_wr_arbiter.sv
// Round-robin AW arbiter sharing one AXI3 write path among MST_NUM masters.
// W beats follow AW grant order through an order FIFO; wlast is checked against awlen.
module axi_wr_arbiter #(
    parameter int unsigned MST_NUM     = 3,
    parameter int unsigned AXI_ADDR_W  = 32,
    parameter int unsigned AXI_ID_W    = 4,
    parameter int unsigned AXI_DATA_W  = 32,
    parameter int unsigned ORDER_DEPTH = 4
) (
    input  logic                                aclk,
    input  logic                                srst,
    input  logic [MST_NUM-1:0]                  s_awvalid,
    output logic [MST_NUM-1:0]                  s_awready,
    input  logic [MST_NUM*AXI_ADDR_W-1:0]       s_awaddr,
    input  logic [MST_NUM*4-1:0]                s_awlen,
    input  logic [MST_NUM*3-1:0]                s_awsize,
    input  logic [MST_NUM*2-1:0]                s_awburst,
    input  logic [MST_NUM*AXI_ID_W-1:0]         s_awid,
    input  logic [MST_NUM*2-1:0]                s_awlock,
    output logic                                m_awvalid,
    input  logic                                m_awready,
    output logic [AXI_ADDR_W-1:0]               m_awaddr,
    output logic [3:0]                          m_awlen,
    output logic [2:0]                          m_awsize,
    output logic [1:0]                          m_awburst,
    output logic [AXI_ID_W-1:0]                 m_awid,
    output logic [1:0]                          m_awlock,
    input  logic [MST_NUM-1:0]                  s_wvalid,
    output logic [MST_NUM-1:0]                  s_wready,
    input  logic [MST_NUM-1:0]                  s_wlast,
    input  logic [MST_NUM*AXI_ID_W-1:0]         s_wid,
    input  logic [MST_NUM*AXI_DATA_W-1:0]       s_wdata,
    input  logic [MST_NUM*(AXI_DATA_W/8)-1:0]   s_wstrb,
    output logic                                m_wvalid,
    input  logic                                m_wready,
    output logic                                m_wlast,
    output logic [AXI_ID_W-1:0]                 m_wid,
    output logic [AXI_DATA_W-1:0]               m_wdata,
    output logic [AXI_DATA_W/8-1:0]             m_wstrb,
    output logic                                wlast_err
);

    localparam int unsigned MST_W  = (MST_NUM > 1) ? $clog2(MST_NUM) : 1;
    localparam int unsigned PTR_W  = (ORDER_DEPTH > 1) ? $clog2(ORDER_DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned STRB_W = AXI_DATA_W / 8;

    typedef struct packed {
        logic [MST_W-1:0] mst;
        logic [3:0]       len;
    } order_t;

    typedef struct packed {
        logic [AXI_ADDR_W-1:0] addr;
        logic [3:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
        logic [AXI_ID_W-1:0]   id;
        logic [1:0]            lock;
    } aw_t;

    logic             m_awvalid_q, m_awvalid_d;
    aw_t              aw_q, aw_d;
    logic [MST_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [MST_W-1:0] grant_c;
    logic             any_req_c, load_c, full_blk_c;
    order_t           mem_q [ORDER_DEPTH];
    order_t           head_c, new_entry_c;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [3:0]       beat_cnt_q, beat_cnt_d;
    logic             wlast_err_q, wlast_err_d;
    logic             head_valid_c, beat_c, pop_c;
    int unsigned      g_idx_c, h_idx_c;

    // First requester at or after the round-robin pointer, wrapping around.
    always_comb begin
        int unsigned idx;
        grant_c   = '0;
        any_req_c = 1'b0;
        idx       = 0;
        for (int unsigned k = 0; k < MST_NUM; k++) begin
            idx = 32'(rr_ptr_q) + k;
            if (idx >= MST_NUM) begin
                idx = idx - MST_NUM;
            end
            if (!any_req_c && s_awvalid[MST_W'(idx)]) begin
                any_req_c = 1'b1;
                grant_c   = MST_W'(idx);
            end
        end
    end

    assign g_idx_c      = 32'(grant_c);
    assign head_c       = mem_q[rd_ptr_q];
    assign h_idx_c      = 32'(head_c.mst);
    assign head_valid_c = (count_q != '0) && !srst;

    // W path follows the FIFO head; nothing routes while it is empty.
    always_comb begin
        m_wvalid = 1'b0;
        m_wlast  = 1'b0;
        m_wid    = '0;
        m_wdata  = '0;
        m_wstrb  = '0;
        s_wready = '0;
        if (head_valid_c) begin
            m_wvalid              = s_wvalid[head_c.mst];
            m_wlast               = s_wlast[head_c.mst];
            m_wid                 = s_wid[h_idx_c*AXI_ID_W +: AXI_ID_W];
            m_wdata               = s_wdata[h_idx_c*AXI_DATA_W +: AXI_DATA_W];
            m_wstrb               = s_wstrb[h_idx_c*STRB_W +: STRB_W];
            s_wready[head_c.mst]  = m_wready;
        end
    end

    assign beat_c = m_wvalid & m_wready;
    assign pop_c  = beat_c & m_wlast;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts a push.
    assign full_blk_c = (count_q == CNT_W'(ORDER_DEPTH)) & ~pop_c;
    assign load_c     = ~srst & (~m_awvalid_q | m_awready) & ~full_blk_c & any_req_c;

    always_comb begin
        s_awready = '0;
        if (load_c) begin
            s_awready[grant_c] = 1'b1;
        end
    end

    assign new_entry_c.mst = grant_c;
    assign new_entry_c.len = s_awlen[g_idx_c*4 +: 4];

    always_comb begin
        m_awvalid_d = m_awvalid_q;
        aw_d        = aw_q;
        rr_ptr_d    = rr_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q + CNT_W'(load_c) - CNT_W'(pop_c);
        beat_cnt_d  = beat_cnt_q;
        wlast_err_d = beat_c & (m_wlast != (beat_cnt_q == head_c.len));
        if (load_c) begin
            m_awvalid_d = 1'b1;
            aw_d.addr   = s_awaddr[g_idx_c*AXI_ADDR_W +: AXI_ADDR_W];
            aw_d.len    = s_awlen[g_idx_c*4 +: 4];
            aw_d.size   = s_awsize[g_idx_c*3 +: 3];
            aw_d.burst  = s_awburst[g_idx_c*2 +: 2];
            aw_d.id     = s_awid[g_idx_c*AXI_ID_W +: AXI_ID_W];
            aw_d.lock   = s_awlock[g_idx_c*2 +: 2];
            rr_ptr_d    = (grant_c == MST_W'(MST_NUM - 1)) ? '0 : MST_W'(grant_c + 1'b1);
            wr_ptr_d    = PTR_W'(wr_ptr_q + 1'b1);
        end else if (m_awready) begin
            m_awvalid_d = 1'b0;
        end
        if (pop_c) begin
            rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
        end
        if (beat_c) begin
            beat_cnt_d = m_wlast ? 4'd0 : 4'(beat_cnt_q + 1'b1);
        end
    end

    always_ff @(posedge aclk) begin
        if (srst) begin
            m_awvalid_q <= 1'b0;
            aw_q        <= '0;
            rr_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            beat_cnt_q  <= '0;
            wlast_err_q <= 1'b0;
        end else begin
            m_awvalid_q <= m_awvalid_d;
            aw_q        <= aw_d;
            rr_ptr_q    <= rr_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            beat_cnt_q  <= beat_cnt_d;
            wlast_err_q <= wlast_err_d;
        end
    end

    // Entry storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge aclk) begin
        if (load_c) begin
            mem_q[wr_ptr_q] <= new_entry_c;
        end
    end

    assign m_awvalid = m_awvalid_q;
    assign m_awaddr  = aw_q.addr;
    assign m_awlen   = aw_q.len;
    assign m_awsize  = aw_q.size;
    assign m_awburst = aw_q.burst;
    assign m_awid    = aw_q.id;
    assign m_awlock  = aw_q.lock;
    assign wlast_err = wlast_err_q;

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Bench for axi_wr_arbiter: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_axi_wr_arbiter;

    localparam int MST = 3;
    localparam int AW = 32;
    localparam int IW = 4;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int DEPTH = 4;

    logic              aclk, srst;
    logic [MST-1:0]    s_awvalid, s_awready;
    logic [MST*AW-1:0] s_awaddr;
    logic [MST*4-1:0]  s_awlen;
    logic [MST*3-1:0]  s_awsize;
    logic [MST*2-1:0]  s_awburst;
    logic [MST*IW-1:0] s_awid;
    logic [MST*2-1:0]  s_awlock;
    logic              m_awvalid, m_awready;
    logic [AW-1:0]     m_awaddr;
    logic [3:0]        m_awlen;
    logic [2:0]        m_awsize;
    logic [1:0]        m_awburst;
    logic [IW-1:0]     m_awid;
    logic [1:0]        m_awlock;
    logic [MST-1:0]    s_wvalid, s_wready, s_wlast;
    logic [MST*IW-1:0] s_wid;
    logic [MST*DW-1:0] s_wdata;
    logic [MST*SW-1:0] s_wstrb;
    logic              m_wvalid, m_wready, m_wlast;
    logic [IW-1:0]     m_wid;
    logic [DW-1:0]     m_wdata;
    logic [SW-1:0]     m_wstrb;
    logic              wlast_err;

    axi_wr_arbiter #(
        .MST_NUM(MST), .AXI_ADDR_W(AW), .AXI_ID_W(IW), .AXI_DATA_W(DW), .ORDER_DEPTH(DEPTH)
    ) dut (
        .aclk(aclk), .srst(srst),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
        .s_awsize(s_awsize), .s_awburst(s_awburst), .s_awid(s_awid), .s_awlock(s_awlock),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
        .m_awsize(m_awsize), .m_awburst(m_awburst), .m_awid(m_awid), .m_awlock(m_awlock),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wlast(s_wlast), .s_wid(s_wid),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wlast(m_wlast), .m_wid(m_wid),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .wlast_err(wlast_err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: outstanding bursts as a queue of {master, len}.
    typedef struct {
        int mst;
        int len;
    } ord_t;

    ord_t        oq[$];
    bit          model_ok = 1'b0;
    bit          e_awv;
    logic [31:0] e_addr;
    logic [3:0]  e_len;
    logic [2:0]  e_size;
    logic [1:0]  e_burst;
    logic [3:0]  e_id;
    logic [1:0]  e_lock;
    int          rr;
    int          bcnt;
    bit          e_err;

    always @(negedge aclk) begin : model
        int h, g;
        bit ne, ewv, ewl, pop, blk, ld;
        logic [MST-1:0] ewr, ear;
        ne  = (oq.size() > 0) && !srst;
        h   = ne ? oq[0].mst : 0;
        ewv = ne && s_wvalid[h +: 1];
        ewl = s_wlast[h +: 1];
        ewr = '0;
        if (ne && m_wready) ewr[h +: 1] = 1'b1;
        pop = ewv && m_wready && ewl;
        blk = (oq.size() >= DEPTH) && !pop;
        ld  = !srst && (!e_awv || m_awready) && !blk && (s_awvalid != '0);
        g = 0;
        for (int k = MST - 1; k >= 0; k--) begin
            if (s_awvalid[(rr + k) % MST +: 1]) g = (rr + k) % MST;
        end
        ear = '0;
        if (ld) ear[g +: 1] = 1'b1;

        if (model_ok) begin
            chk("s_awready", 64'(s_awready), 64'(ear));
            chk("m_awvalid", 64'(m_awvalid), 64'(e_awv));
            if (e_awv) begin
                chk("m_awaddr", 64'(m_awaddr), 64'(e_addr));
                chk("m_awlen", 64'(m_awlen), 64'(e_len));
                chk("m_awsize", 64'(m_awsize), 64'(e_size));
                chk("m_awburst", 64'(m_awburst), 64'(e_burst));
                chk("m_awid", 64'(m_awid), 64'(e_id));
                chk("m_awlock", 64'(m_awlock), 64'(e_lock));
            end
            chk("m_wvalid", 64'(m_wvalid), 64'(ewv));
            chk("s_wready", 64'(s_wready), 64'(ewr));
            if (ne) begin
                chk("m_wlast", 64'(m_wlast), 64'(ewl));
                chk("m_wid", 64'(m_wid), 64'(s_wid[h*IW +: IW]));
                chk("m_wdata", 64'(m_wdata), 64'(s_wdata[h*DW +: DW]));
                chk("m_wstrb", 64'(m_wstrb), 64'(s_wstrb[h*SW +: SW]));
            end
            chk("wlast_err", 64'(wlast_err), 64'(e_err));
        end

        if (srst) begin
            e_awv = 1'b0; e_addr = '0; e_len = '0; e_size = '0;
            e_burst = '0; e_id = '0; e_lock = '0;
            rr = 0; bcnt = 0; e_err = 1'b0;
            oq.delete();
            model_ok = 1'b1;
        end else begin
            e_err = 1'b0;
            if (ewv && m_wready) begin
                e_err = (ewl != (bcnt == oq[0].len));
                if (ewl) begin
                    void'(oq.pop_front());
                    bcnt = 0;
                end else begin
                    bcnt = (bcnt + 1) % 16;
                end
            end
            if (ld) begin
                oq.push_back('{mst: g, len: int'(s_awlen[g*4 +: 4])});
                e_awv   = 1'b1;
                e_addr  = s_awaddr[g*AW +: AW];
                e_len   = s_awlen[g*4 +: 4];
                e_size  = s_awsize[g*3 +: 3];
                e_burst = s_awburst[g*2 +: 2];
                e_id    = s_awid[g*IW +: IW];
                e_lock  = s_awlock[g*2 +: 2];
                rr      = (g + 1) % MST;
            end else if (m_awready) begin
                e_awv = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic drain(input int n);
        s_awvalid = '0;
        s_wvalid  = '1;
        s_wlast   = '1;
        m_wready  = 1'b1;
        m_awready = 1'b1;
        repeat (n) step();
        s_wvalid = '0;
    endtask

    logic [2:0]  exp_rr   [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    logic [31:0] exp_addr [5] = '{32'hA000_0000, 32'hA000_0100, 32'hA000_0200,
                                  32'hA000_0000, 32'hA000_0100};
    logic [2:0]  exp_full [4] = '{3'b010, 3'b100, 3'b001, 3'b010};

    initial begin
        srst = 1'b1;
        s_awvalid = '1; m_awready = 1'b1;
        s_wvalid = '0; s_wlast = '0; m_wready = 1'b1;
        for (int m = 0; m < MST; m++) begin
            s_awaddr[m*AW +: AW]  = 32'hA000_0000 + 32'(m) * 32'h100;
            s_awlen[m*4 +: 4]     = 4'd0;
            s_awsize[m*3 +: 3]    = 3'(m + 1);
            s_awburst[m*2 +: 2]   = 2'd1;
            s_awid[m*IW +: IW]    = 4'(4 * m + 1);
            s_awlock[m*2 +: 2]    = 2'(m);
            s_wid[m*IW +: IW]     = 4'(4 * m + 1);
            s_wdata[m*DW +: DW]   = 32'hD0D0_0000 + 32'(m);
            s_wstrb[m*SW +: SW]   = 4'(m + 12);
        end

        // Reset held two cycles with every master requesting
        settle();
        chk("rst_awready_c0", 64'(s_awready), 64'd0);
        step();
        settle();
        chk("rst_awready_c1", 64'(s_awready), 64'd0);
        chk("rst_awvalid", 64'(m_awvalid), 64'd0);
        chk("rst_wready", 64'(s_wready), 64'd0);
        chk("rst_wlast_err", 64'(wlast_err), 64'd0);
        step();
        srst = 1'b0;
        s_awvalid = '0;
        step();

        // Round-robin fairness with one burst drained per cycle
        s_awvalid = 3'b111; m_awready = 1'b1;
        s_wvalid = 3'b111; s_wlast = 3'b111; m_wready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            settle();
            chk("rr_grant", 64'(s_awready), 64'(exp_rr[k]));
            if (k > 0) chk("rr_awaddr", 64'(m_awaddr), 64'(exp_addr[k-1]));
            step();
        end
        drain(2);

        // Downstream AW backpressure
        m_awready = 1'b0; s_awvalid = 3'b010;
        settle();
        chk("bp_first_grant", 64'(s_awready), 64'b010);
        step();
        s_awvalid = 3'b011;
        s_awaddr[1*AW +: AW] = 32'hDEAD_0000;
        for (int k = 0; k < 5; k++) begin
            settle();
            chk("bp_no_grant", 64'(s_awready), 64'd0);
            chk("bp_valid_held", 64'(m_awvalid), 64'd1);
            chk("bp_addr_stable", 64'(m_awaddr), 64'hA000_0100);
            step();
        end
        m_awready = 1'b1;
        settle();
        chk("bp_release_grant", 64'(s_awready), 64'b001);
        step();
        s_awvalid = '0;
        s_awaddr[1*AW +: AW] = 32'hA000_0100;
        step();
        drain(3);

        // W ordering: M2 burst of 4 must finish before M0's early beat
        s_awlen[2*4 +: 4] = 4'd3;
        s_awvalid = 3'b100; s_wvalid = 3'b001; s_wlast = 3'b001;
        settle();
        chk("ord_grant_m2", 64'(s_awready), 64'b100);
        chk("ord_empty_wready", 64'(s_wready), 64'd0);
        step();
        s_awvalid = 3'b001; s_wvalid = 3'b101;
        settle();
        chk("ord_grant_m0", 64'(s_awready), 64'b001);
        chk("ord_m2_beat0", 64'(s_wready), 64'b100);
        step();
        s_awvalid = '0;
        for (int k = 1; k < 3; k++) begin
            settle();
            chk("ord_m2_mid", 64'(s_wready), 64'b100);
            step();
        end
        s_wlast = 3'b101;
        settle();
        chk("ord_m2_last_wready", 64'(s_wready), 64'b100);
        chk("ord_m2_wlast", 64'(m_wlast), 64'd1);
        step();
        s_wvalid = 3'b001;
        settle();
        chk("ord_m0_wready", 64'(s_wready), 64'b001);
        chk("ord_m0_wdata", 64'(m_wdata), 64'hD0D0_0000);
        step();
        s_wvalid = '0; s_wlast = '0;
        s_awlen[2*4 +: 4] = 4'd0;
        step();

        // Order FIFO full, then pop and push in the same cycle
        s_awvalid = 3'b111; m_awready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("full_fill_grant", 64'(s_awready), 64'(exp_full[k]));
            step();
        end
        settle();
        chk("full_blocked", 64'(s_awready), 64'd0);
        step();
        s_wvalid = 3'b111; s_wlast = 3'b111;
        settle();
        chk("full_pop_wready", 64'(s_wready), 64'b010);
        chk("full_pop_grant", 64'(s_awready), 64'b100);
        step();
        drain(5);

        // Early wlast on M0 (awlen=2), then M1 burst must still route
        s_awlen[0 +: 4] = 4'd2; s_awlen[4 +: 4] = 4'd1;
        s_awvalid = 3'b001; s_wlast = '0;
        settle();
        chk("err_grant_m0", 64'(s_awready), 64'b001);
        step();
        s_awvalid = 3'b010; s_wvalid = 3'b001;
        settle();
        chk("err_grant_m1", 64'(s_awready), 64'b010);
        step();
        s_awvalid = '0; s_wlast = 3'b001;
        step();
        s_wvalid = 3'b010; s_wlast = '0;
        settle();
        chk("err_pulse", 64'(wlast_err), 64'd1);
        chk("err_next_route", 64'(s_wready), 64'b010);
        step();
        s_wlast = 3'b010;
        settle();
        chk("err_pulse_once", 64'(wlast_err), 64'd0);
        step();
        s_wvalid = '0; s_wlast = '0;
        settle();
        chk("err_clean_burst", 64'(wlast_err), 64'd0);
        step();

        // Missing wlast on single-beat M2: flagged, not popped, then late wlast flagged
        s_awvalid = 3'b100;
        step();
        s_awvalid = '0; s_wvalid = 3'b100; s_wlast = '0;
        step();
        s_wlast = 3'b100;
        settle();
        chk("miss_wlast_err", 64'(wlast_err), 64'd1);
        chk("miss_no_pop", 64'(s_wready), 64'b100);
        step();
        s_wvalid = '0; s_wlast = '0;
        settle();
        chk("late_wlast_err", 64'(wlast_err), 64'd1);
        step();
        settle();
        chk("late_err_clear", 64'(wlast_err), 64'd0);
        s_awlen = '0;
        step();

        // Reset mid-burst flushes in-flight state
        s_awlen[0 +: 4] = 4'd3; s_awvalid = 3'b001;
        step();
        s_awvalid = '0; s_wvalid = 3'b001; s_wlast = '0;
        step();
        srst = 1'b1;
        step();
        srst = 1'b0;
        settle();
        chk("mid_rst_wready", 64'(s_wready), 64'd0);
        chk("mid_rst_awvalid", 64'(m_awvalid), 64'd0);
        step();
        s_wvalid = '0; s_awlen = '0;
        s_awvalid = 3'b100;
        settle();
        chk("post_rst_grant", 64'(s_awready), 64'b100);
        step();
        drain(2);
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
